// File: rtl/tree_root_drain.sv
// Root drain stage of the merge sorter tree: credit-controlled record requests,
// FWFT output FIFO, run completion tracking and sticky order/protocol error flags.
module tree_root_drain #(
    parameter int DATW      = 64,
    parameter int KEYW      = 32,
    parameter int FIFO_SIZE = 4,
    parameter int CNTW      = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [CNTW-1:0] TOTAL,
    input  logic            STAGE_QUEUE_FULL,
    output logic            REQ_VALID,
    input  logic [DATW-1:0] DIN,
    input  logic            DINEN,
    output logic [DATW-1:0] DOT,
    output logic            DOT_VALID,
    input  logic            DOT_READY,
    output logic            BUSY,
    output logic            DONE,
    output logic [CNTW-1:0] COUNT,
    output logic            SORT_ERR,
    output logic            PROTO_ERR
);

    localparam int DEPTH = 2 ** FIFO_SIZE;
    localparam int CW    = FIFO_SIZE + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNTW-1:0]     total_r;
    logic [CNTW-1:0]     req_left_r;
    logic [CNTW-1:0]     count_r;
    logic [CW-1:0]       outstanding_r;
    logic [CW-1:0]       fifo_cnt_r;
    logic [FIFO_SIZE-1:0] head_r;
    logic [FIFO_SIZE-1:0] tail_r;
    logic [DATW-1:0]     mem_r [DEPTH];
    logic [KEYW-1:0]     prev_key_r;
    logic                prev_valid_r;
    logic                sort_err_r;
    logic                proto_err_r;

    logic                start_acc_s;
    logic                req_s;
    logic                inc_s;
    logic                dec_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                proto_hit_s;
    logic [CW-1:0]       credit_s;
    logic [KEYW-1:0]     dot_key_s;

    // Credits count both buffered and still-in-flight records so the FIFO cannot overflow.
    assign credit_s    = fifo_cnt_r + outstanding_r;
    assign start_acc_s = START && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign req_s       = (state_r == S_RUN) && (req_left_r != '0) && !STAGE_QUEUE_FULL
                         && (credit_s < CW'(DEPTH));
    assign fifo_full_s = (fifo_cnt_r == CW'(DEPTH));
    assign push_s      = DINEN && !fifo_full_s;
    assign pop_s       = (fifo_cnt_r != '0) && DOT_READY;
    assign inc_s       = req_s;
    assign dec_s       = DINEN && (outstanding_r != '0);
    assign proto_hit_s = DINEN && ((outstanding_r == '0) || fifo_full_s);
    assign dot_key_s   = DOT[KEYW-1:0];

    // Next-state decode; START only takes effect from IDLE or DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_acc_s) begin
                    state_s = (TOTAL == '0) ? S_DONE : S_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            S_RUN: begin
                if (req_left_r == '0) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (count_r == total_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run bookkeeping: request budget, credits, emitted count and sticky error flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            total_r       <= '0;
            req_left_r    <= '0;
            count_r       <= '0;
            outstanding_r <= '0;
            prev_key_r    <= '0;
            prev_valid_r  <= 1'b0;
            sort_err_r    <= 1'b0;
            proto_err_r   <= 1'b0;
        end else if (start_acc_s) begin
            total_r       <= TOTAL;
            req_left_r    <= TOTAL;
            count_r       <= '0;
            outstanding_r <= '0;
            prev_valid_r  <= 1'b0;
            sort_err_r    <= 1'b0;
            proto_err_r   <= 1'b0;
        end else begin
            if (req_s) begin
                req_left_r <= req_left_r - CNTW'(1);
            end
            case ({inc_s, dec_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (proto_hit_s) begin
                proto_err_r <= 1'b1;
            end
            if (pop_s) begin
                count_r      <= count_r + CNTW'(1);
                prev_key_r   <= dot_key_s;
                prev_valid_r <= 1'b1;
                if (prev_valid_r && (dot_key_s < prev_key_r)) begin
                    sort_err_r <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the FIFO depth.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head_r     <= '0;
            tail_r     <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + FIFO_SIZE'(1);
            end
            if (pop_s) begin
                head_r <= head_r + FIFO_SIZE'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Record storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[tail_r] <= DIN;
        end
    end

    assign REQ_VALID = req_s;
    assign DOT       = mem_r[head_r];
    assign DOT_VALID = (fifo_cnt_r != '0);
    assign BUSY      = (state_r == S_RUN) || (state_r == S_DRAIN);
    assign DONE      = (state_r == S_DONE);
    assign COUNT     = count_r;
    assign SORT_ERR  = sort_err_r;
    assign PROTO_ERR = proto_err_r;

endmodule

// File: tb/tb_tree_root_drain.sv
// Directed bench for tree_root_drain: a top-stage responder with fixed latency,
// an output monitor against an expected record queue, and linear directed steps.
module tb_tree_root_drain;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [31:0] TOTAL = 32'd0;
    logic        STAGE_QUEUE_FULL = 1'b0;
    logic        REQ_VALID;
    logic [63:0] DIN = 64'd0;
    logic        DINEN = 1'b0;
    logic [63:0] DOT;
    logic        DOT_VALID;
    logic        DOT_READY = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] COUNT;
    logic        SORT_ERR;
    logic        PROTO_ERR;

    int checks = 0;
    int errors = 0;
    int req_count = 0;
    int inj_cnt = 0;
    int inj_done = 0;
    logic [63:0] inj_data = 64'd0;
    logic [2:0]  dly = 3'b000;
    logic [63:0] key_q[$];
    logic [63:0] exp_q[$];

    tree_root_drain dut (
        .CLK(CLK), .RST(RST), .START(START), .TOTAL(TOTAL),
        .STAGE_QUEUE_FULL(STAGE_QUEUE_FULL), .REQ_VALID(REQ_VALID),
        .DIN(DIN), .DINEN(DINEN), .DOT(DOT), .DOT_VALID(DOT_VALID),
        .DOT_READY(DOT_READY), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT),
        .SORT_ERR(SORT_ERR), .PROTO_ERR(PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    // Top-stage model: each request returns the next queued record three cycles later.
    always @(negedge CLK) begin
        if (inj_cnt != inj_done) begin
            DINEN = 1'b1;
            DIN = inj_data;
            inj_done++;
        end else if (dly[2]) begin
            DINEN = 1'b1;
            if (key_q.size() > 0) DIN = key_q.pop_front();
            else DIN = 64'd0;
        end else begin
            DINEN = 1'b0;
        end
        dly = {dly[1:0], REQ_VALID & RST};
        if (REQ_VALID) req_count++;
    end

    // Output monitor: every handed-off record must match the expected stream.
    always @(negedge CLK) begin
        logic [63:0] exp_d;
        if (RST && DOT_VALID && DOT_READY) begin
            if (exp_q.size() > 0) exp_d = exp_q.pop_front();
            else exp_d = 64'hDEAD_DEAD_DEAD_DEAD;
            checks++;
            assert (DOT === exp_d) else begin
                errors++;
                $error("FAIL dot_data observed=%h expected=%h", DOT, exp_d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_key(input logic [31:0] k);
        key_q.push_back({~k, k});
        exp_q.push_back({~k, k});
    endtask

    task automatic start_run(input logic [31:0] n);
        TOTAL = n;
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, {63'd0, DONE}, 64'd1);
    endtask

    initial begin
        int r0;
        int bad;

        // Reset values
        tick(2);
        chk("rst_req_valid", {63'd0, REQ_VALID}, 64'd0);
        chk("rst_dot_valid", {63'd0, DOT_VALID}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_count", {32'd0, COUNT}, 64'd0);
        chk("rst_errs", {62'd0, SORT_ERR, PROTO_ERR}, 64'd0);
        RST = 1'b1;
        tick(2);

        // Basic run: keys 1..5
        for (int i = 1; i <= 5; i++) push_key(32'(i));
        DOT_READY = 1'b1;
        r0 = req_count;
        start_run(32'd5);
        chk("basic_busy", {63'd0, BUSY}, 64'd1);
        wait_done("basic_done", 100);
        chk("basic_reqs", 64'(req_count - r0), 64'd5);
        chk("basic_count", {32'd0, COUNT}, 64'd5);
        chk("basic_busy_end", {63'd0, BUSY}, 64'd0);
        chk("basic_errs", {62'd0, SORT_ERR, PROTO_ERR}, 64'd0);
        chk("basic_all_out", 64'(exp_q.size()), 64'd0);

        // Backpressure: 40 records, consumer stalled for 100 cycles
        for (int i = 0; i < 40; i++) push_key(32'(100 + 3 * i));
        DOT_READY = 1'b0;
        r0 = req_count;
        start_run(32'd40);
        tick(100);
        chk("bp_reqs_stall", 64'(req_count - r0), 64'd16);
        chk("bp_req_low", {63'd0, REQ_VALID}, 64'd0);
        chk("bp_fifo_cnt", 64'(dut.fifo_cnt_r), 64'd16);
        chk("bp_proto", {63'd0, PROTO_ERR}, 64'd0);
        DOT_READY = 1'b1;
        wait_done("bp_done", 300);
        chk("bp_reqs", 64'(req_count - r0), 64'd40);
        chk("bp_count", {32'd0, COUNT}, 64'd40);
        chk("bp_errs", {62'd0, SORT_ERR, PROTO_ERR}, 64'd0);
        chk("bp_all_out", 64'(exp_q.size()), 64'd0);

        // Stage queue full held for 10 cycles mid-run
        for (int i = 0; i < 30; i++) push_key(32'(500 + i));
        r0 = req_count;
        start_run(32'd30);
        tick(5);
        STAGE_QUEUE_FULL = 1'b1;
        bad = req_count;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (REQ_VALID !== 1'b0) bad = bad - 1000;
            tick(1);
        end
        chk("sqf_no_reqs", 64'(req_count - bad), 64'd0);
        STAGE_QUEUE_FULL = 1'b0;
        #1;
        chk("sqf_resume", {63'd0, REQ_VALID}, 64'd1);
        wait_done("sqf_done", 300);
        chk("sqf_reqs", 64'(req_count - r0), 64'd30);
        chk("sqf_count", {32'd0, COUNT}, 64'd30);
        chk("sqf_errs", {62'd0, SORT_ERR, PROTO_ERR}, 64'd0);

        // Ordering error: keys 3,7,5 popped one at a time
        push_key(32'd3);
        push_key(32'd7);
        push_key(32'd5);
        DOT_READY = 1'b0;
        start_run(32'd3);
        tick(20);
        chk("ord_pre", {63'd0, SORT_ERR}, 64'd0);
        DOT_READY = 1'b1;
        tick(1);
        chk("ord_pop3", {63'd0, SORT_ERR}, 64'd0);
        tick(1);
        chk("ord_pop7", {63'd0, SORT_ERR}, 64'd0);
        tick(1);
        chk("ord_pop5", {63'd0, SORT_ERR}, 64'd1);
        wait_done("ord_done", 20);
        chk("ord_sticky", {63'd0, SORT_ERR}, 64'd1);
        chk("ord_proto", {63'd0, PROTO_ERR}, 64'd0);
        r0 = req_count;
        start_run(32'd0);
        chk("ord_cleared", {63'd0, SORT_ERR}, 64'd0);
        chk("tot0_done_again", {63'd0, DONE}, 64'd1);

        // Asynchronous reset mid-run
        for (int i = 0; i < 20; i++) push_key(32'(900 + i));
        start_run(32'd20);
        tick(8);
        chk("mid_busy", {63'd0, BUSY}, 64'd1);
        RST = 1'b0;
        #1;
        chk("arst_req_valid", {63'd0, REQ_VALID}, 64'd0);
        chk("arst_dot_valid", {63'd0, DOT_VALID}, 64'd0);
        chk("arst_busy_done", {62'd0, BUSY, DONE}, 64'd0);
        chk("arst_count", {32'd0, COUNT}, 64'd0);
        chk("arst_errs", {62'd0, SORT_ERR, PROTO_ERR}, 64'd0);
        tick(5);
        key_q.delete();
        exp_q.delete();
        RST = 1'b1;
        tick(2);
        chk("post_rst_idle", {61'd0, BUSY, DONE, PROTO_ERR}, 64'd0);

        // Unsolicited record in IDLE
        inj_data = 64'h1234_5678_9ABC_DEF0;
        exp_q.push_back(inj_data);
        inj_cnt++;
        tick(4);
        chk("unsol_proto", {63'd0, PROTO_ERR}, 64'd1);
        chk("unsol_out", 64'(exp_q.size()), 64'd0);
        chk("unsol_busy", {63'd0, BUSY}, 64'd0);

        // TOTAL=0 from IDLE: DONE next cycle, no requests, errors cleared
        r0 = req_count;
        start_run(32'd0);
        chk("tot0_done", {63'd0, DONE}, 64'd1);
        chk("tot0_busy", {63'd0, BUSY}, 64'd0);
        chk("tot0_proto_clr", {63'd0, PROTO_ERR}, 64'd0);
        tick(3);
        chk("tot0_reqs", 64'(req_count - r0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
